// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
//   - F3M_* : funct3 encodings of the RV64 M-extension ops.
//   - muldiv_state_t : sequencer FSM states.
//   - small decode helpers used by the sequencer.
package muldiv_sequencer_pkg;

  localparam logic [2:0] F3M_MUL    = 3'b000;
  localparam logic [2:0] F3M_MULH   = 3'b001;
  localparam logic [2:0] F3M_MULHSU = 3'b010;
  localparam logic [2:0] F3M_MULHU  = 3'b011;
  localparam logic [2:0] F3M_DIV    = 3'b100;
  localparam logic [2:0] F3M_DIVU   = 3'b101;
  localparam logic [2:0] F3M_REM    = 3'b110;
  localparam logic [2:0] F3M_REMU   = 3'b111;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} muldiv_state_t;

  // All multiply encodings have funct3[2] clear.
  function automatic logic f3m_is_mul(input logic [2:0] f3);
    return !f3[2];
  endfunction

  function automatic logic f3m_is_signed_div(input logic [2:0] f3);
    return (f3 == F3M_DIV) || (f3 == F3M_REM);
  endfunction

  function automatic logic f3m_is_rem(input logic [2:0] f3);
    return f3[2] && f3[1];
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring-divider datapath: one quotient bit per clock.
// Ports:
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   start_i          : load new operands (magnitudes) and begin
//   width_32_i       : run 32 iterations on the low 32 bits instead of XLEN
//   dividend_i       : unsigned dividend magnitude
//   divisor_i        : unsigned divisor magnitude (nonzero)
//   quotient_o       : quotient magnitude (low 32 bits valid for W forms)
//   remainder_o      : remainder magnitude
//   done_o           : high during the cycle whose edge performs the last iteration
module muldiv_div_core
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            start_i,
  input  logic            width_32_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            fits;

  // quo_q doubles as the dividend shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    fits      = (rem_shift >= {1'b0, dvs_q});
    if (start_i) begin
      rem_d = '0;
      dvs_d = divisor_i;
      // W forms park the 32-bit dividend at the top so iteration order matches.
      quo_d = width_32_i ? {dividend_i[31:0], {(XLEN-32){1'b0}}} : dividend_i;
      cnt_d = width_32_i ? CW'(32) : CW'(XLEN);
    end else if (cnt_q != '0) begin
      rem_d = fits ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], fits};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o      = (cnt_q == CW'(1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle execution controller for RV64 M-extension ops.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds its payload until then, and the consumer side
// (resp_*) is held stable while resp_valid && !resp_ready.
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset
//   req_valid/ready    : request handshake (ready only in IDLE without flush)
//   req_funct3         : F3M_* op select
//   req_width_32       : -W variant
//   req_a, req_b       : rs1, rs2
//   req_tag            : destination tag, echoed on resp_tag
//   flush              : kill the in-flight op, no response
//   resp_valid/ready   : result handshake
//   resp_result        : result value
//   resp_tag           : tag of the result
//   busy               : state != IDLE
//   dbg_state_o        : current FSM state
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic             req_width_32,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output muldiv_state_t    dbg_state_o
);

  muldiv_state_t    state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]       f3_q, f3_d;
  logic             w32_q, w32_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic             dz_q, dz_d, ovf_q, ovf_d;
  logic [XLEN-1:0]  result_q, result_d;

  // ---------------- request decode ----------------
  logic            accept, req_signed, b_zero, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
  logic            div_start, div_done;
  logic [XLEN-1:0] div_quo, div_rem;

  assign req_ready = (state_q == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign req_signed = f3m_is_signed_div(req_funct3);

  // Operands are normalised to XLEN at accept: W forms are sign- or
  // zero-extended from bit 31 so one magnitude/sign path serves both widths.
  always_comb begin
    a_ext = req_a;
    b_ext = req_b;
    if (req_width_32) begin
      a_ext = {{(XLEN-32){req_signed & req_a[31]}}, req_a[31:0]};
      b_ext = {{(XLEN-32){req_signed & req_b[31]}}, req_b[31:0]};
    end
    a_mag   = (req_signed && a_ext[XLEN-1]) ? -a_ext : a_ext;
    b_mag   = (req_signed && b_ext[XLEN-1]) ? -b_ext : b_ext;
    min_val = req_width_32 ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    b_zero  = (b_ext == '0);
    ovf     = req_signed && (a_ext == min_val) && (b_ext == '1);
  end

  // ---------------- multiply result ----------------
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic              mul_a_signed, mul_b_signed;
  logic [XLEN-1:0]   mul_res;

  assign mul_a_signed = (f3_q == F3M_MULH) || (f3_q == F3M_MULHSU);
  assign mul_b_signed = (f3_q == F3M_MULH);
  assign mul_a   = {{XLEN{mul_a_signed & a_q[XLEN-1]}}, a_q};
  assign mul_b   = {{XLEN{mul_b_signed & b_q[XLEN-1]}}, b_q};
  // Truncating a 2XLEN x 2XLEN product to 2XLEN bits is exact for any
  // signedness mix once both operands are extended accordingly.
  assign product = mul_a * mul_b;

  always_comb begin
    if (f3_q == F3M_MUL)
      mul_res = w32_q ? {{(XLEN-32){product[31]}}, product[31:0]} : product[XLEN-1:0];
    else
      mul_res = w32_q ? {{(XLEN-32){1'b0}}, 32'hDEADBEEF} : product[2*XLEN-1:XLEN];
  end

  // ---------------- divide result ----------------
  logic [XLEN-1:0] quo_v, rem_v, div_sel, div_res;

  always_comb begin
    if (dz_q) begin
      quo_v = '1;
      rem_v = a_q;
    end else if (ovf_q) begin
      quo_v = a_q;
      rem_v = '0;
    end else begin
      quo_v = q_neg_q ? -div_quo : div_quo;
      rem_v = r_neg_q ? -div_rem : div_rem;
    end
    div_sel = f3m_is_rem(f3_q) ? rem_v : quo_v;
    div_res = w32_q ? {{(XLEN-32){div_sel[31]}}, div_sel[31:0]} : div_sel;
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .start_i     (div_start),
    .width_32_i  (req_width_32),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  // ---------------- FSM ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    f3_d      = f3_q;
    w32_d     = w32_q;
    tag_d     = tag_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a_ext;
          b_d     = b_ext;
          f3_d    = req_funct3;
          w32_d   = req_width_32;
          tag_d   = req_tag;
          q_neg_d = req_signed & (a_ext[XLEN-1] ^ b_ext[XLEN-1]);
          r_neg_d = req_signed & a_ext[XLEN-1];
          dz_d    = b_zero;
          ovf_d   = ovf;
          if (f3m_is_mul(req_funct3)) begin
            state_d = MUL;
            cnt_d   = 4'(MUL_LAT);
          end else if (b_zero || ovf) begin
            // Special cases need no iterations; FIX builds the result.
            state_d = FIX;
          end else begin
            state_d   = DIV;
            div_start = 1'b1;
          end
        end
      end
      MUL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = DONE;
          result_d = mul_res;
        end
      end
      DIV: begin
        if (div_done) state_d = FIX;
      end
      FIX: begin
        state_d  = DONE;
        result_d = div_res;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including a pending resp_ready.
    if (flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      w32_q    <= 1'b0;
      tag_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      w32_q    <= w32_d;
      tag_q    <= tag_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign resp_valid  = (state_q == DONE);
  assign resp_result = result_q;
  assign resp_tag    = tag_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic          clk;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_funct3;
  logic          req_width_32;
  logic [63:0]   req_a, req_b;
  logic [4:0]    req_tag;
  logic          flush;
  logic          resp_valid;
  logic          resp_ready;
  logic [63:0]   resp_result;
  logic [4:0]    resp_tag;
  logic          busy;
  muldiv_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(64), .MUL_LAT(2), .TAG_W(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_width_32 (req_width_32),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tag      (req_tag),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_tag     (resp_tag),
    .busy         (busy),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Presents one request, lets it be accepted on the next edge, then counts
  // negedges until resp_valid is seen. lat = -1 if it never appears.
  task automatic do_op(input logic [2:0] f3, input logic w32, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = f3; req_width_32 = w32;
    req_a = a; req_b = b; req_tag = tag;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_result !== 64'h0) begin errors++; $display("FAIL reset_resp_result: got %h want 0", resp_result); end
    checks++; if (resp_tag !== 5'h0) begin errors++; $display("FAIL reset_resp_tag: got %h want 0", resp_tag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [2:0]  f3_v [7];
    logic        w_v  [7];
    logic [63:0] a_v  [7];
    logic [63:0] b_v  [7];
    logic [63:0] e_v  [7];
    int lat;
    f3_v = '{F3M_MULH, F3M_MUL, F3M_MULHSU, F3M_MULHU, F3M_MUL, F3M_MULH, F3M_MULH};
    w_v  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    a_v  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h0000_0000_8000_0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
    b_v  = '{64'd2, 64'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd1, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF};
    e_v  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
             64'hFFFF_FFFF_8000_0000, 64'h0000_0000_DEAD_BEEF, 64'h0};
    for (int i = 0; i < 7; i++) begin
      do_op(f3_v[i], w_v[i], a_v[i], b_v[i], 5'(i + 16), lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL mul%0d_latency: got %0d want 3", i, lat); end
      checks++; if (resp_result !== e_v[i]) begin errors++; $display("FAIL mul%0d_result: got %h want %h", i, resp_result, e_v[i]); end
      checks++; if (resp_tag !== 5'(i + 16)) begin errors++; $display("FAIL mul%0d_tag: got %h want %h", i, resp_tag, 5'(i + 16)); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3_v [12];
    logic        w_v  [12];
    logic [63:0] a_v  [12];
    logic [63:0] b_v  [12];
    logic [63:0] e_v  [12];
    int          l_v  [12];
    int lat;
    f3_v = '{F3M_DIV, F3M_REM, F3M_DIVU, F3M_DIVU, F3M_REMU, F3M_REM, F3M_DIV,
             F3M_DIVU, F3M_DIV, F3M_REM, F3M_REM, F3M_DIV};
    w_v  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    a_v  = '{64'd100, 64'd100, 64'd100, 64'd123, 64'd123,
             64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
             64'h1234_5678_8000_0000, 64'hABCD_0000_FFFF_FFEC, 64'hABCD_0000_FFFF_FFEC,
             64'h0000_0000_8000_0005, 64'h0000_0000_8000_0000};
    b_v  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 64'd0, 64'd0,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd1, 64'd3, 64'd3, 64'd0, 64'h0000_0000_FFFF_FFFF};
    e_v  = '{64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 64'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'd123,
             64'h0, 64'h8000_0000_0000_0000,
             64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE,
             64'hFFFF_FFFF_8000_0005, 64'hFFFF_FFFF_8000_0000};
    l_v  = '{66, 66, 66, 2, 2, 2, 2, 34, 34, 34, 2, 2};
    for (int i = 0; i < 12; i++) begin
      do_op(f3_v[i], w_v[i], a_v[i], b_v[i], 5'(i), lat);
      checks++; if (lat !== l_v[i]) begin errors++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, l_v[i]); end
      checks++; if (resp_result !== e_v[i]) begin errors++; $display("FAIL div%0d_result: got %h want %h", i, resp_result, e_v[i]); end
      checks++; if (resp_tag !== 5'(i)) begin errors++; $display("FAIL div%0d_tag: got %h want %h", i, resp_tag, 5'(i)); end
    end
  endtask

  task automatic test_flush();
    int seen;
    // Kill a running DIV at cycle 10.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = F3M_DIV; req_width_32 = 1'b0;
    req_a = 64'd100; req_b = 64'd7; req_tag = 5'h0A;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    checks++; if (dbg_state !== DIV) begin errors++; $display("FAIL flush_pre_state: got %0d want %0d", dbg_state, DIV); end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_req_ready: got %b want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_resp: got %0d resp cycles want 0", seen); end
    // A request alongside flush is not taken.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_ready: got %b want 0", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got busy %b want 0", busy); end
  endtask

  task automatic test_hold();
    int lat;
    resp_ready = 1'b0;
    do_op(F3M_MUL, 1'b0, 64'd7, 64'd6, 5'h03, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL hold_latency: got %0d want 3", lat); end
    // Offer a competing request while DONE; it must be ignored.
    req_valid = 1'b1; req_funct3 = F3M_MUL; req_a = 64'd9; req_b = 64'd9; req_tag = 5'h09;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_valid: got %b want 1", i, resp_valid); end
      checks++; if (resp_result !== 64'd42) begin errors++; $display("FAIL hold%0d_result: got %h want %h", i, resp_result, 64'd42); end
      checks++; if (resp_tag !== 5'h03) begin errors++; $display("FAIL hold%0d_tag: got %h want 03", i, resp_tag); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_req_ready: got %b want 0", i, req_ready); end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b want 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_release_no_accept: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = F3M_MUL; req_width_32 = 1'b0;
    req_a = 64'd5; req_b = 64'd5; req_tag = 5'h1F;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (dbg_state !== MUL) begin errors++; $display("FAIL rst_mul_pre_state: got %0d want %0d", dbg_state, MUL); end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mul_valid: got %b want 0", resp_valid); end
    checks++; if (resp_result !== 64'h0) begin errors++; $display("FAIL rst_mul_result: got %h want 0", resp_result); end
    checks++; if (resp_tag !== 5'h0) begin errors++; $display("FAIL rst_mul_tag: got %h want 0", resp_tag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mul_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mul_no_resp: got %0d resp cycles want 0", seen); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_funct3 = 3'b0; req_width_32 = 1'b0;
    req_a = '0; req_b = '0; req_tag = '0; flush = 1'b0; resp_ready = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_hold();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle execution controller for the RV64 M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus the -W forms). It replaces the single-cycle combinational multiply/divide path.
- Multiplies: latched operands, fixed-latency pipeline modelled by a counter.
- Divides: iterative restoring divider, one quotient bit per cycle.
- Issue stage hands it one op at a time over valid/ready and receives a tagged result over valid/ready.

Parameters:
- XLEN, 64, datapath width.
- MUL_LAT, 2, cycles spent in MUL state before the result is presented (range 1..15).
- TAG_W, 5, width of the destination tag carried through.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_funct3  in  3  F3M_* op select.
- req_width_32  in  1  -W variant: use low 32 bits, sign-extend the 32-bit result.
- req_a  in  XLEN  rs1.
- req_b  in  XLEN  rs2.
- req_tag  in  TAG_W  destination tag.
- flush  in  1  kill the in-flight op.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer accepts the result.
- resp_result  out  XLEN  result.
- resp_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, resp_valid=0, resp_result=0, resp_tag=0, busy=0, counter=0. Reset mid-operation discards the op; no response is produced.
- Register reset values are checked on the first edge with reset_n=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- req_ready = (state==IDLE) && !flush. A request is accepted on an edge where req_valid && req_ready; operands, funct3, width_32 and tag are latched.
- Requests are never accepted in DONE, including the cycle resp_ready is high. Back-to-back ops therefore have at least one IDLE cycle between them.
- Accept of MUL, MULH, MULHSU or MULHU:
  - IDLE->MUL, counter=MUL_LAT.
  - Counter decrements each cycle; at counter==1, MUL->DONE with the result registered.
  - resp_valid first high MUL_LAT+1 cycles after the accept edge (3 at default).
- Multiply result selection:
  - MUL: low XLEN of the product.
  - MULH: high XLEN of signed×signed.
  - MULHSU: high XLEN of signed×unsigned.
  - MULHU: high XLEN of unsigned×unsigned.
  - W form (MUL only): sign-extend product[31:0]. MULH/MULHSU/MULHU with width_32 are illegal; the response carries 64'hDEADBEEF.
- Accept of DIV, DIVU, REM or REMU, normal path:
  - Operand width N = 32 if width_32, else XLEN; W forms take the low 32 bits of a and b.
  - Signed ops (DIV, REM) take absolute values and record the quotient sign (a^b sign) and remainder sign (a sign).
  - IDLE->DIV for exactly N cycles, one restoring iteration per cycle.
  - DIV->FIX: apply signs, select quotient or remainder, sign-extend from bit 31 for W forms.
  - FIX->DONE. resp_valid first high N+2 cycles after the accept edge (66 for 64-bit, 34 for W).
- Divide special cases, detected at accept; these go IDLE->FIX directly, with resp_valid at accept+2:
  - Divisor==0: quotient = all ones; remainder = dividend (sign-extended for W forms).
  - Signed overflow (dividend = most-negative N-bit value and divisor = -1): quotient = dividend; remainder = 0.
- DONE:
  - resp_valid=1; resp_result and resp_tag are held stable while resp_ready=0.
  - An edge with resp_ready=1 moves DONE->IDLE, resp_valid=0.
- flush=1 at an edge, any state: next state IDLE, resp_valid=0, no response for the killed op.
  - A request presented in the same cycle as flush is not accepted.
  - Flush has priority over resp_ready.
- busy = (state!=IDLE).

Decomposition:
- Shared package holds:
  - the existing F3M_* funct3 constants, which are reused and not redefined;
  - the new typedef enum logic [2:0] muldiv_state_t {IDLE, MUL, DIV, FIX, DONE}.
- Sub-module muldiv_div_core: restoring-divider datapath.
  - Inputs: start, width_32, unsigned magnitudes.
  - Outputs: quotient/remainder magnitudes, done after N iterations.
  - It holds the remainder/quotient shift registers; muldiv_sequencer owns the FSM, sign handling, special cases and handshakes.

Test Plan:
- MULH, a=64'hFFFF_FFFF_FFFF_FFFF, b=2 -> resp_result=64'hFFFF_FFFF_FFFF_FFFF, resp_valid at accept+3, tag echoed.
- DIV, a=100, b=-7 (64-bit) -> resp_result=-14 (64'hFFFF_FFFF_FFFF_FFF2) at accept+66. REM with the same operands -> 2.
- DIVU, b=0, a=123 -> 64'hFFFF_FFFF_FFFF_FFFF at accept+2. REMU with the same operands -> 123.
- REM, a=64'h8000_0000_0000_0000, b=-1 -> 0. DIV with the same operands -> 64'h8000_0000_0000_0000. Both at accept+2.
- DIVUW, a=64'h1234_5678_8000_0000, b=1 -> 64'hFFFF_FFFF_8000_0000 at accept+34.
- Control sequence:
  - flush at cycle 10 of a DIV -> no resp_valid, req_ready high the next cycle.
  - Hold resp_ready=0 for 5 cycles in DONE -> result and tag stable.
  - reset_n=0 mid-MUL -> all outputs 0 after the edge.
